dca_matrix_register_stream: RTL and testbench
=============================================

Name: dca_matrix_register_stream

Overview:
Parametrised successor of the DCA square matrix register. It stores a ROWS x COLS matrix of scalars. Row traffic in and out uses streaming valid/ready handshakes driven by an internal load/drain state machine. In-place operations are shift-up, shift-left (each with zero-fill or rotate), and transpose when the matrix is square. The block sits between the DCA tensor DMA/stream fabric and the compute array, which reads the full matrix and the top row directly.

Parameters:
NUM_ROWS, 8, matrix row count (>=2)
NUM_COLS, 8, matrix column count (>=2)
BW_TENSOR_SCALAR, 32, bits per element
RESET_VALUE, 0, element value after reset
INIT_VALUE, RESET_VALUE, element value loaded by init
BW_ROW, NUM_COLS*BW_TENSOR_SCALAR, derived: row bus width
BW_MATRIX, NUM_ROWS*BW_ROW, derived: full matrix width
BW_PTR, clog2(NUM_ROWS), derived: row pointer width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
init  in  1  sync: all elements <- INIT_VALUE, FSM -> IDLE
load_start  in  1  begin streaming load of NUM_ROWS rows
drain_start  in  1  begin streaming drain of NUM_ROWS rows
wr_valid  in  1  input row valid
wr_ready  out  1  input row accepted when wr_valid&wr_ready
wr_data  in  BW_ROW  input row; element c at bits [c*BW+:BW]
rd_valid  out  1  output row valid
rd_ready  in  1  output row consumed when rd_valid&rd_ready
rd_data  out  BW_ROW  output row
shift_up  in  1  row r <- row r+1; bottom row <- fill
shift_left  in  1  col c <- col c+1; rightmost col <- fill
rotate  in  1  fill source: 0 = zeros, 1 = wrapped row/col
transpose  in  1  element(r,c) <- element(c,r); square only
busy  out  1  FSM not IDLE
done  out  1  one-cycle pulse at the end of a load or drain
row_ptr  out  BW_PTR  current load/drain row index
all_rdata_list2d  out  BW_MATRIX  full matrix; row r at [r*BW_ROW+:BW_ROW]
upmost_rdata_list1d  out  BW_ROW  row 0

Behaviour:
- Reset (rst=1, asynchronous):
  - all elements = RESET_VALUE
  - FSM = IDLE, row_ptr = 0
  - wr_ready = rd_valid = busy = done = 0
- States: IDLE, LOAD, DRAIN. All outputs are registered except rd_data, which is a combinational mux of row[row_ptr].
- IDLE command priority (exactly one acts per cycle): init > load_start > drain_start > transpose > shift_up > shift_left. Lower-priority commands in the same cycle are dropped.
- load_start in IDLE:
  - next cycle: LOAD, row_ptr = 0, wr_ready = 1
  - each wr handshake writes row[row_ptr] <- wr_data and increments row_ptr
  - handshake at row_ptr = NUM_ROWS-1: next cycle IDLE, wr_ready = 0, done = 1, row_ptr = 0
  - wr_valid while not in LOAD is ignored (wr_ready = 0)
- drain_start in IDLE:
  - next cycle: DRAIN, row_ptr = 0, rd_valid = 1
  - rd_data holds stable while rd_valid & !rd_ready
  - each rd handshake increments row_ptr
  - handshake at NUM_ROWS-1: next cycle IDLE, rd_valid = 0, done = 1
  - drain is non-destructive; matrix contents are unchanged
- In LOAD/DRAIN: load_start, drain_start, shift_up, shift_left and transpose are ignored. init aborts to IDLE immediately (next edge): row_ptr = 0, wr_ready = rd_valid = 0, no done pulse.
- shift_up: row r <- row r+1 for r < NUM_ROWS-1. Bottom row <- old row 0 if rotate, else zeros.
- shift_left: per row, elem c <- elem c+1. Rightmost <- old elem 0 if rotate, else zeros.
- transpose: applied only when NUM_ROWS == NUM_COLS; otherwise a no-op in the cycle.
- All matrix updates take effect at the next clock edge; all_rdata_list2d and upmost_rdata_list1d reflect them one cycle after the command.
- done is high for exactly one cycle. busy = (state != IDLE).
- rst asserted mid-LOAD/DRAIN: immediate reset state. Partially loaded rows revert to RESET_VALUE.

Test Plan:
- Reset then release: all_rdata_list2d all RESET_VALUE; wr_ready = rd_valid = busy = done = 0; row_ptr = 0.
- 4x3 instance, BW=8: load_start, then rows 0x030201, 0x060504, 0x090807, 0x0C0B0A with wr_valid gapped every other cycle -> exactly 4 handshakes; done pulses one cycle after the 4th; upmost = 0x030201.
- Drain the same matrix with rd_ready toggling 1,0,1,1,0,1 -> rd_data sequence 0x030201, 0x060504, 0x090807, 0x0C0B0A, each stable while stalled; done once; matrix unchanged.
- From the loaded matrix:
  - shift_up, rotate=1 -> row 3 = 0x030201
  - shift_left, rotate=0 -> row 0 = 0x000302
  - shift_up & shift_left together -> only shift_up takes effect
- 3x3 instance: transpose of elements 1..9 (row-major) -> row 0 = {7,4,1} at element positions 2,1,0. On 4x3, transpose -> matrix unchanged.
- init asserted on the second handshake cycle of a LOAD -> all elements = INIT_VALUE, IDLE, no done pulse. Separately, rst pulsed mid-DRAIN -> rd_valid = 0 asynchronously.

Source files
------------

// File: rtl/dca_matrix_register_stream.sv
// ROWS x COLS scalar matrix register with streaming row load/drain and in-place
// shift-up, shift-left (zero-fill or rotate) and square transpose.
module dca_matrix_register_stream #(
   parameter int                            NUM_ROWS         = 8,
   parameter int                            NUM_COLS         = 8,
   parameter int                            BW_TENSOR_SCALAR = 32,
   parameter logic [BW_TENSOR_SCALAR-1:0]   RESET_VALUE      = '0,
   parameter logic [BW_TENSOR_SCALAR-1:0]   INIT_VALUE       = RESET_VALUE,
   parameter int                            BW_ROW           = NUM_COLS * BW_TENSOR_SCALAR,
   parameter int                            BW_MATRIX        = NUM_ROWS * BW_ROW,
   parameter int                            BW_PTR           = $clog2(NUM_ROWS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 init,
   input  logic                 load_start,
   input  logic                 drain_start,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [BW_ROW-1:0]    wr_data,
   output logic                 rd_valid,
   input  logic                 rd_ready,
   output logic [BW_ROW-1:0]    rd_data,
   input  logic                 shift_up,
   input  logic                 shift_left,
   input  logic                 rotate,
   input  logic                 transpose,
   output logic                 busy,
   output logic                 done,
   output logic [BW_PTR-1:0]    row_ptr,
   output logic [BW_MATRIX-1:0] all_rdata_list2d,
   output logic [BW_ROW-1:0]    upmost_rdata_list1d
);

   localparam int BW  = BW_TENSOR_SCALAR;
   localparam int DIM = (NUM_ROWS < NUM_COLS) ? NUM_ROWS : NUM_COLS;
   localparam logic [BW_PTR-1:0]    LAST_ROW = BW_PTR'(NUM_ROWS - 1);
   localparam logic [BW_MATRIX-1:0] RST_MAT  = {(NUM_ROWS * NUM_COLS){RESET_VALUE}};
   localparam logic [BW_MATRIX-1:0] INIT_MAT = {(NUM_ROWS * NUM_COLS){INIT_VALUE}};

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN} state_e;
   typedef logic [NUM_ROWS-1:0][BW_ROW-1:0] mat_t;

   mat_t              mat_q, mat_d;
   state_e            state_q, state_d;
   logic [BW_PTR-1:0] ptr_q, ptr_d;
   logic              wr_ready_q, wr_ready_d;
   logic              rd_valid_q, rd_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   function automatic mat_t f_shift_up(input mat_t m, input logic rot);
      mat_t r;
      for (int i = 0; i < NUM_ROWS - 1; i++) r[i] = m[i+1];
      r[NUM_ROWS-1] = rot ? m[0] : '0;
      return r;
   endfunction

   function automatic mat_t f_shift_left(input mat_t m, input logic rot);
      mat_t r;
      for (int i = 0; i < NUM_ROWS; i++)
         r[i] = {(rot ? m[i][BW-1:0] : {BW{1'b0}}), m[i][BW_ROW-1:BW]};
      return r;
   endfunction

   // Loops are bounded by the smaller dimension so non-square builds elaborate cleanly.
   function automatic mat_t f_transpose(input mat_t m);
      mat_t r;
      r = m;
      for (int i = 0; i < DIM; i++)
         for (int j = 0; j < DIM; j++)
            r[i][j*BW +: BW] = m[j][i*BW +: BW];
      return r;
   endfunction

   always_comb begin
      mat_d   = mat_q;
      state_d = state_q;
      ptr_d   = ptr_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (init) begin
               mat_d = INIT_MAT;
            end else if (load_start) begin
               state_d = ST_LOAD;
               ptr_d   = '0;
            end else if (drain_start) begin
               state_d = ST_DRAIN;
               ptr_d   = '0;
            end else if (transpose) begin
               if (NUM_ROWS == NUM_COLS) mat_d = f_transpose(mat_q);
            end else if (shift_up) begin
               mat_d = f_shift_up(mat_q, rotate);
            end else if (shift_left) begin
               mat_d = f_shift_left(mat_q, rotate);
            end
         end
         ST_LOAD: begin
            if (init) begin
               mat_d   = INIT_MAT;
               state_d = ST_IDLE;
               ptr_d   = '0;
            end else if (wr_valid && wr_ready_q) begin
               mat_d[ptr_q] = wr_data;
               if (ptr_q == LAST_ROW) begin
                  state_d = ST_IDLE;
                  ptr_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  ptr_d = ptr_q + BW_PTR'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (init) begin
               mat_d   = INIT_MAT;
               state_d = ST_IDLE;
               ptr_d   = '0;
            end else if (rd_valid_q && rd_ready) begin
               if (ptr_q == LAST_ROW) begin
                  state_d = ST_IDLE;
                  ptr_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  ptr_d = ptr_q + BW_PTR'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            ptr_d   = '0;
         end
      endcase
      wr_ready_d = (state_d == ST_LOAD);
      rd_valid_d = (state_d == ST_DRAIN);
      busy_d     = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mat_q      <= RST_MAT;
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         wr_ready_q <= 1'b0;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         mat_q      <= mat_d;
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         wr_ready_q <= wr_ready_d;
         rd_valid_q <= rd_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign wr_ready            = wr_ready_q;
   assign rd_valid            = rd_valid_q;
   assign busy                = busy_q;
   assign done                = done_q;
   assign row_ptr             = ptr_q;
   assign rd_data             = mat_q[ptr_q];
   assign all_rdata_list2d    = mat_q;
   assign upmost_rdata_list1d = mat_q[0];

endmodule

// File: tb/tb_dca_matrix_register_stream.sv
// Bench for dca_matrix_register_stream: a 4x3 and a 3x3 instance checked against
// an array model every cycle, plus directed handshake and literal checks.
module tb_dca_matrix_register_stream;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // 4x3 instance, reset 0xA5, init 0x5A
   logic        a_init = 0, a_load = 0, a_drain = 0, a_wv = 0, a_rr = 0;
   logic        a_su = 0, a_sl = 0, a_rot = 0, a_tr = 0;
   logic [23:0] a_wd = '0;
   logic        a_wr, a_rv, a_busy, a_done;
   logic [23:0] a_rd, a_up;
   logic [1:0]  a_ptr;
   logic [95:0] a_all;

   // 3x3 instance, defaults for reset/init
   logic        b_init = 0, b_load = 0, b_drain = 0, b_wv = 0, b_rr = 0;
   logic        b_su = 0, b_sl = 0, b_rot = 0, b_tr = 0;
   logic [23:0] b_wd = '0;
   logic        b_wr, b_rv, b_busy, b_done;
   logic [23:0] b_rd, b_up;
   logic [1:0]  b_ptr;
   logic [71:0] b_all;

   dca_matrix_register_stream #(
      .NUM_ROWS(4), .NUM_COLS(3), .BW_TENSOR_SCALAR(8),
      .RESET_VALUE(8'hA5), .INIT_VALUE(8'h5A)
   ) u_a (
      .clk(clk), .rst(rst), .init(a_init), .load_start(a_load), .drain_start(a_drain),
      .wr_valid(a_wv), .wr_ready(a_wr), .wr_data(a_wd),
      .rd_valid(a_rv), .rd_ready(a_rr), .rd_data(a_rd),
      .shift_up(a_su), .shift_left(a_sl), .rotate(a_rot), .transpose(a_tr),
      .busy(a_busy), .done(a_done), .row_ptr(a_ptr),
      .all_rdata_list2d(a_all), .upmost_rdata_list1d(a_up)
   );

   dca_matrix_register_stream #(
      .NUM_ROWS(3), .NUM_COLS(3), .BW_TENSOR_SCALAR(8)
   ) u_b (
      .clk(clk), .rst(rst), .init(b_init), .load_start(b_load), .drain_start(b_drain),
      .wr_valid(b_wv), .wr_ready(b_wr), .wr_data(b_wd),
      .rd_valid(b_rv), .rd_ready(b_rr), .rd_data(b_rd),
      .shift_up(b_su), .shift_left(b_sl), .rotate(b_rot), .transpose(b_tr),
      .busy(b_busy), .done(b_done), .row_ptr(b_ptr),
      .all_rdata_list2d(b_all), .upmost_rdata_list1d(b_up)
   );

   int errors = 0;
   int checks = 0;
   logic chk_en = 1'b0;

   int ma [4][3];
   int mb [3][3];

   logic [23:0] rows_a [4];
   logic [23:0] rows_b [3];
   logic [95:0] pa;
   logic [71:0] pb;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [95:0] pack_a();
      logic [95:0] v;
      v = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++) v[r*24 + c*8 +: 8] = 8'(ma[r][c]);
      return v;
   endfunction

   function automatic logic [71:0] pack_b();
      logic [71:0] v;
      v = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) v[r*24 + c*8 +: 8] = 8'(mb[r][c]);
      return v;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 4; r++) for (int c = 0; c < 3; c++) ma[r][c] = 8'hA5;
      for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) mb[r][c] = 0;
   endtask

   // Model of one IDLE-cycle command on the 4x3 matrix (transpose is a no-op there).
   task automatic model_cmd_a(input logic su, input logic sl, input logic tr, input logic rot);
      int t [4][3];
      t = ma;
      if (tr) begin
      end else if (su) begin
         for (int r = 0; r < 3; r++) ma[r] = t[r+1];
         for (int c = 0; c < 3; c++) ma[3][c] = rot ? t[0][c] : 0;
      end else if (sl) begin
         for (int r = 0; r < 4; r++) begin
            ma[r][0] = t[r][1];
            ma[r][1] = t[r][2];
            ma[r][2] = rot ? t[r][0] : 0;
         end
      end
   endtask

   task automatic cmd_a(input logic su, input logic sl, input logic tr, input logic rot);
      @(posedge clk); #1;
      a_su = su; a_sl = sl; a_tr = tr; a_rot = rot;
      @(posedge clk);
      model_cmd_a(su, sl, tr, rot);
      #1;
      a_su = 0; a_sl = 0; a_tr = 0; a_rot = 0;
   endtask

   task automatic cmd_b_transpose(input logic su);
      int t [3][3];
      @(posedge clk); #1;
      b_tr = 1; b_su = su;
      @(posedge clk);
      t = mb;
      for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) mb[r][c] = t[c][r];
      #1;
      b_tr = 0; b_su = 0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         pa = pack_a();
         pb = pack_b();
         check("A_matrix", a_all, pa);
         check("A_upmost", 96'(a_up), 96'(pa[23:0]));
         check("B_matrix", 96'(b_all), 96'(pb));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, required finish within time limit");
      $fatal(1);
   end

   initial begin
      int hs, cyc, early, n, k;
      logic go;
      logic rr_pat [6];
      rows_a = '{24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A};
      rows_b = '{24'h030201, 24'h060504, 24'h090807};
      rr_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      model_reset();

      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(negedge clk);
      check("reset_flags_A", 96'({a_wr, a_rv, a_busy, a_done}), 96'(0));
      check("reset_ptr_A", 96'(a_ptr), 96'(0));
      check("reset_matrix_A", a_all, {12{8'hA5}});
      check("reset_matrix_B", 96'(b_all), 96'(0));

      // wr_valid outside LOAD must not be accepted
      @(posedge clk); #1;
      a_wv = 1; a_wd = 24'hEEEEEE;
      @(negedge clk);
      check("A_wr_ready_idle", 96'(a_wr), 96'(0));
      @(posedge clk); #1;
      a_wv = 0;

      // gapped streaming load
      a_load = 1;
      @(posedge clk); #1;
      a_load = 0;
      @(negedge clk);
      check("A_load_entry", 96'({a_busy, a_wr, a_rv, a_ptr}), 96'(5'b11000));
      @(posedge clk); #1;
      hs = 0; cyc = 0; early = 0;
      while (hs < 4 && cyc < 40) begin
         a_wv = cyc[0];
         a_wd = a_wv ? rows_a[hs] : 24'hFFFFFF;
         @(negedge clk);
         if (a_done) early++;
         go = a_wv & a_wr;
         @(posedge clk);
         if (go) begin
            for (int c = 0; c < 3; c++) ma[hs][c] = int'(rows_a[hs][c*8 +: 8]);
            hs++;
         end
         #1;
         cyc++;
      end
      a_wv = 0;
      check("A_load_handshakes", 96'(hs), 96'(4));
      check("A_load_early_done", 96'(early), 96'(0));
      @(negedge clk);
      check("A_load_done", 96'({a_done, a_busy, a_wr, a_ptr}), 96'(5'b10000));
      check("A_load_upmost", 96'(a_up), 96'(24'h030201));
      @(posedge clk); #1;
      @(negedge clk);
      check("A_load_done_once", 96'(a_done), 96'(0));

      // drain with rd_ready stalls
      @(posedge clk); #1;
      a_drain = 1;
      @(posedge clk); #1;
      a_drain = 0;
      n = 0; k = 0; early = 0;
      while (n < 4 && k < 20) begin
         a_rr = rr_pat[k % 6];
         @(negedge clk);
         check("A_rd_valid", 96'(a_rv), 96'(1));
         check("A_rd_data", 96'(a_rd), 96'(rows_a[n]));
         if (a_done) early++;
         go = a_rr & a_rv;
         @(posedge clk);
         if (go) n++;
         #1;
         k++;
      end
      a_rr = 0;
      check("A_drain_handshakes", 96'(n), 96'(4));
      check("A_drain_cycles", 96'(k), 96'(6));
      check("A_drain_early_done", 96'(early), 96'(0));
      @(negedge clk);
      check("A_drain_done", 96'({a_done, a_busy, a_rv, a_ptr}), 96'(5'b10000));
      @(posedge clk); #1;
      @(negedge clk);
      check("A_drain_done_once", 96'(a_done), 96'(0));

      // in-place operations
      cmd_a(1, 0, 0, 1);
      @(negedge clk);
      check("A_shift_up_rot_row3", 96'(a_all[72 +: 24]), 96'(24'h030201));
      repeat (3) cmd_a(1, 0, 0, 1);
      cmd_a(0, 1, 0, 0);
      @(negedge clk);
      check("A_shift_left_zero_row0", 96'(a_up), 96'(24'h000302));
      cmd_a(1, 1, 0, 0);
      @(negedge clk);
      check("A_up_over_left_row0", 96'(a_up), 96'(24'h000605));
      check("A_up_over_left_row3", 96'(a_all[72 +: 24]), 96'(0));
      cmd_a(0, 0, 1, 0);
      @(negedge clk);
      check("A_transpose_nonsquare", a_all,
            {24'h000000, 24'h000C0B, 24'h000908, 24'h000605});

      // 3x3 load and transpose
      @(posedge clk); #1;
      b_load = 1;
      @(posedge clk); #1;
      b_load = 0;
      hs = 0; cyc = 0;
      while (hs < 3 && cyc < 20) begin
         b_wv = 1;
         b_wd = rows_b[hs];
         @(negedge clk);
         go = b_wv & b_wr;
         @(posedge clk);
         if (go) begin
            for (int c = 0; c < 3; c++) mb[hs][c] = int'(rows_b[hs][c*8 +: 8]);
            hs++;
         end
         #1;
         cyc++;
      end
      b_wv = 0;
      check("B_load_handshakes", 96'(hs), 96'(3));
      @(negedge clk);
      check("B_load_done", 96'(b_done), 96'(1));
      cmd_b_transpose(0);
      @(negedge clk);
      check("B_transpose_row0", 96'(b_up), 96'(24'h070401));
      cmd_b_transpose(1);
      @(negedge clk);
      check("B_transpose_over_shift", 96'(b_up), 96'(24'h030201));

      // init on the second handshake cycle of a load
      @(posedge clk); #1;
      a_load = 1;
      @(posedge clk); #1;
      a_load = 0;
      a_wv = 1; a_wd = 24'h111111;
      @(posedge clk);
      for (int c = 0; c < 3; c++) ma[0][c] = 8'h11;
      #1;
      a_wd = 24'h222222; a_init = 1;
      @(posedge clk);
      for (int r = 0; r < 4; r++) for (int c = 0; c < 3; c++) ma[r][c] = 8'h5A;
      #1;
      a_init = 0; a_wv = 0;
      @(negedge clk);
      check("A_init_abort_flags", 96'({a_done, a_busy, a_wr, a_ptr}), 96'(0));
      check("A_init_matrix", a_all, {12{8'h5A}});
      @(posedge clk); #1;
      @(negedge clk);
      check("A_init_no_done", 96'(a_done), 96'(0));

      // asynchronous reset mid-drain
      @(posedge clk); #1;
      a_drain = 1;
      @(posedge clk); #1;
      a_drain = 0; a_rr = 0;
      @(negedge clk);
      check("A_drain_before_rst", 96'(a_rv), 96'(1));
      #2 rst = 1'b1;
      #1;
      check("A_rst_async_rd_valid", 96'({a_rv, a_busy}), 96'(0));
      model_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("A_rst_matrix", a_all, {12{8'hA5}});
      check("A_rst_ptr", 96'(a_ptr), 96'(0));

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
